// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit field positions and egress arbiter states shared by the VC buffer
package noc_flit_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_LOCK
    } arb_state_e;

    function automatic int tail_bit(input int flit_width);
        return flit_width - 1;
    endfunction

    function automatic int head_bit(input int flit_width);
        return flit_width - 2;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// noc_flit_fifo: one virtual channel's flit FIFO; read data comes from registered state only
module noc_flit_fifo #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [FLIT_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [FLIT_WIDTH-1:0] rdata,
    output logic [CW-1:0]         count
);
    localparam int PW = $clog2(DEPTH);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;

    assign rdata = mem[rd_ptr];

    // storage is not reset; count alone decides whether an entry is visible
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;

    // pointers wrap explicitly so DEPTH need not be a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/noc_flit_vc_buffer.sv
// noc_flit_vc_buffer: per-VC flit FIFOs feeding one egress port through a wormhole round-robin arbiter
module noc_flit_vc_buffer
    import noc_flit_pkg::*;
#(
    parameter int FLIT_WIDTH = 32,
    parameter int VCS        = 2,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [VCS-1:0]            i_valid,
    output logic [VCS-1:0]            o_ready,
    input  logic [VCS*FLIT_WIDTH-1:0] i_flit,
    output logic [VCS-1:0]            o_valid,
    input  logic [VCS-1:0]            i_ready,
    output logic [FLIT_WIDTH-1:0]     o_flit
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = VCS > 1 ? $clog2(VCS) : 1;
    localparam int TB = tail_bit(FLIT_WIDTH);

    logic [VCS-1:0]        push;
    logic [VCS-1:0]        pop;
    logic [VCS-1:0]        avail;
    logic [CW-1:0]         count [VCS];
    logic [FLIT_WIDTH-1:0] rdata [VCS];
    arb_state_e            state;
    logic [GW-1:0]         grant;
    logic [GW-1:0]         rr_ptr;
    logic [GW-1:0]         next_vc;
    logic [GW-1:0]         start;
    logic [GW-1:0]         pick;
    logic [GW-1:0]         idx;
    logic                  tail_pop;

    for (genvar v = 0; v < VCS; v++) begin : g_vc
        assign o_ready[v] = !rst && count[v] < CW'(DEPTH);
        assign push[v]    = i_valid[v] && o_ready[v];
        assign o_valid[v] = state != ARB_IDLE && grant == GW'(v) && count[v] != '0;
        assign pop[v]     = o_valid[v] && i_ready[v];
        // a VC is a candidate if it will still hold a flit after this edge
        assign avail[v]   = push[v] || count[v] > CW'(pop[v]);
        noc_flit_fifo #(
            .FLIT_WIDTH(FLIT_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk  (clk),
            .rst  (rst),
            .push (push[v]),
            .wdata(i_flit[v*FLIT_WIDTH +: FLIT_WIDTH]),
            .pop  (pop[v]),
            .rdata(rdata[v]),
            .count(count[v])
        );
    end

    assign o_flit   = |o_valid ? rdata[grant] : '0;
    assign tail_pop = |pop && o_flit[TB];
    assign next_vc  = grant == GW'(VCS - 1) ? '0 : grant + 1'b1;
    assign start    = tail_pop ? next_vc : rr_ptr;

    // first candidate at or after start; scanning backwards lets the nearest one win
    always_comb begin
        pick = start;
        idx  = start;
        for (int i = VCS - 1; i >= 0; i--) begin
            idx = GW'((int'(start) + i) % VCS);
            if (avail[idx]) pick = idx;
        end
    end

    // grant is held until a tail flit leaves; only then does the round-robin pointer advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else if (state == ARB_IDLE || tail_pop) begin
            if (tail_pop) rr_ptr <= next_vc;
            state <= |avail ? ARB_GRANT : ARB_IDLE;
            if (|avail) grant <= pick;
        end else if (|pop) begin
            state <= ARB_LOCK;
        end
    end

endmodule

// File: tb/tb_noc_flit_vc_buffer.sv
// tb_noc_flit_vc_buffer: directed scenario tests for the VC flit buffer with hand-computed expectations
module tb_noc_flit_vc_buffer;
    localparam int FW    = 32;
    localparam int VCS   = 2;
    localparam int DEPTH = 4;
    localparam logic [FW-1:0] HT = 32'hC000_0000;
    localparam logic [FW-1:0] H  = 32'h4000_0000;
    localparam logic [FW-1:0] T  = 32'h8000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [VCS-1:0]    i_valid = '0;
    logic [VCS-1:0]    i_ready = '0;
    logic [VCS*FW-1:0] i_flit = '0;
    logic [VCS-1:0]    o_ready;
    logic [VCS-1:0]    o_valid;
    logic [FW-1:0]     o_flit;
    int errors = 0;
    int checks = 0;

    noc_flit_vc_buffer #(.FLIT_WIDTH(FW), .VCS(VCS), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_flit (i_flit),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_flit (o_flit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        i_valid = '0;
        i_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (o_ready !== 2'b00) begin errors++; $display("FAIL reset_ready_in_rst: o_ready=%b expected 00", o_ready); end
        checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: o_valid=%b expected 00", o_valid); end
        checks++; if (o_flit !== '0) begin errors++; $display("FAIL reset_flit: o_flit=%h expected 0", o_flit); end
        rst = 1'b0;
        #1;
        checks++; if (o_ready !== 2'b11) begin errors++; $display("FAIL reset_ready_after: o_ready=%b expected 11", o_ready); end
    endtask

    task automatic test_fill_drain();
        logic [FW-1:0] exp;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            i_valid = 2'b01;
            i_flit[0 +: FW] = 32'hA0 + k;
            tick();
        end
        checks++; if (o_ready !== 2'b10) begin errors++; $display("FAIL fill_full_ready: o_ready=%b expected 10", o_ready); end
        checks++; if (o_valid !== 2'b01 || o_flit !== 32'hA0) begin errors++; $display("FAIL fill_head: o_valid=%b o_flit=%h expected 01 a0", o_valid, o_flit); end
        i_flit[0 +: FW] = 32'hA4;
        tick();
        checks++; if (o_ready !== 2'b10) begin errors++; $display("FAIL fill_fifth_held: o_ready=%b expected 10", o_ready); end
        i_valid = '0;
        i_ready = 2'b01;
        for (int k = 0; k < 4; k++) begin
            exp = 32'hA0 + k;
            checks++; if (o_valid !== 2'b01 || o_flit !== exp) begin errors++; $display("FAIL drain_order[%0d]: o_valid=%b o_flit=%h expected 01 %h", k, o_valid, o_flit, exp); end
            tick();
        end
        checks++; if (o_valid !== 2'b00 || o_ready !== 2'b11) begin errors++; $display("FAIL drain_empty: o_valid=%b o_ready=%b expected 00 11", o_valid, o_ready); end
        i_ready = '0;
    endtask

    task automatic test_latency();
        apply_reset();
        i_valid = 2'b01;
        i_flit[0 +: FW] = HT | 32'h11;
        #1;
        checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL latency_same_cycle: o_valid=%b expected 00", o_valid); end
        tick();
        i_valid = '0;
        checks++; if (o_valid !== 2'b01 || o_flit !== (HT | 32'h11)) begin errors++; $display("FAIL latency_next_cycle: o_valid=%b o_flit=%h expected 01 %h", o_valid, o_flit, HT | 32'h11); end
        i_ready = 2'b01;
        tick();
        checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL latency_popped: o_valid=%b expected 00", o_valid); end
        i_ready = '0;
    endtask

    task automatic test_wormhole();
        apply_reset();
        i_valid = 2'b11;
        i_flit[0 +: FW]  = H | 32'h01;
        i_flit[FW +: FW] = HT | 32'h10;
        tick();
        i_valid = '0;
        checks++; if (o_valid !== 2'b01 || o_flit !== (H | 32'h01)) begin errors++; $display("FAIL worm_head: o_valid=%b o_flit=%h expected 01 %h", o_valid, o_flit, H | 32'h01); end
        i_ready = 2'b11;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL worm_gap[%0d]: o_valid=%b expected 00", k, o_valid); end
        end
        i_valid = 2'b01;
        i_flit[0 +: FW] = 32'h02;
        tick();
        i_flit[0 +: FW] = T | 32'h03;
        checks++; if (o_valid !== 2'b01 || o_flit !== 32'h02) begin errors++; $display("FAIL worm_body: o_valid=%b o_flit=%h expected 01 00000002", o_valid, o_flit); end
        tick();
        i_valid = '0;
        checks++; if (o_valid !== 2'b01 || o_flit !== (T | 32'h03)) begin errors++; $display("FAIL worm_tail: o_valid=%b o_flit=%h expected 01 %h", o_valid, o_flit, T | 32'h03); end
        tick();
        checks++; if (o_valid !== 2'b10 || o_flit !== (HT | 32'h10)) begin errors++; $display("FAIL worm_vc1_after: o_valid=%b o_flit=%h expected 10 %h", o_valid, o_flit, HT | 32'h10); end
        tick();
        checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL worm_idle: o_valid=%b expected 00", o_valid); end
        i_ready = '0;
    endtask

    task automatic test_round_robin();
        logic [VCS-1:0] exp_v;
        logic [FW-1:0]  exp_f;
        apply_reset();
        i_ready = 2'b11;
        i_valid = 2'b11;
        i_flit[0 +: FW]  = HT | 32'hB0;
        i_flit[FW +: FW] = HT | 32'hB1;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_v = k % 2 == 1 ? 2'b10 : 2'b01;
            exp_f = k % 2 == 1 ? (HT | 32'hB1) : (HT | 32'hB0);
            checks++; if (o_valid !== exp_v || o_flit !== exp_f) begin errors++; $display("FAIL rr_grant[%0d]: o_valid=%b o_flit=%h expected %b %h", k, o_valid, o_flit, exp_v, exp_f); end
            tick();
        end
        i_valid = '0;
        i_ready = '0;
    endtask

    task automatic test_back_to_back_full();
        logic [FW-1:0] exp;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            i_valid = 2'b01;
            i_flit[0 +: FW] = HT | (32'hC0 + k);
            tick();
        end
        i_flit[0 +: FW] = HT | 32'hC4;
        i_ready = 2'b01;
        checks++; if (o_ready !== 2'b10) begin errors++; $display("FAIL full_ready_low: o_ready=%b expected 10", o_ready); end
        tick();
        checks++; if (o_ready !== 2'b11 || o_valid !== 2'b01 || o_flit !== (HT | 32'hC1)) begin errors++; $display("FAIL full_pop_refuse: o_ready=%b o_valid=%b o_flit=%h expected 11 01 %h", o_ready, o_valid, o_flit, HT | 32'hC1); end
        tick();
        i_valid = '0;
        for (int k = 2; k < 5; k++) begin
            exp = HT | (32'hC0 + k);
            checks++; if (o_valid !== 2'b01 || o_flit !== exp) begin errors++; $display("FAIL full_drain[%0d]: o_valid=%b o_flit=%h expected 01 %h", k, o_valid, o_flit, exp); end
            tick();
        end
        checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL full_empty: o_valid=%b expected 00", o_valid); end
        i_ready = '0;
    endtask

    task automatic test_reset_mid_packet();
        apply_reset();
        i_valid = 2'b01;
        i_flit[0 +: FW] = HT | 32'h09;
        tick();
        i_valid = '0;
        i_ready = 2'b01;
        tick();
        i_ready = '0;
        i_valid = 2'b01;
        i_flit[0 +: FW] = H | 32'hD0;
        tick();
        i_valid = 2'b11;
        i_flit[0 +: FW]  = 32'hD1;
        i_flit[FW +: FW] = HT | 32'hE0;
        tick();
        i_valid = 2'b01;
        i_flit[0 +: FW] = T | 32'hD2;
        tick();
        i_valid = '0;
        i_ready = 2'b01;
        tick();
        tick();
        checks++; if (o_valid !== 2'b01 || o_flit !== (T | 32'hD2)) begin errors++; $display("FAIL mid_before_reset: o_valid=%b o_flit=%h expected 01 %h", o_valid, o_flit, T | 32'hD2); end
        rst = 1'b1;
        tick();
        checks++; if (o_ready !== 2'b00 || o_valid !== 2'b00 || o_flit !== '0) begin errors++; $display("FAIL mid_in_reset: o_ready=%b o_valid=%b o_flit=%h expected 00 00 0", o_ready, o_valid, o_flit); end
        rst = 1'b0;
        #1;
        checks++; if (o_ready !== 2'b11 || o_valid !== 2'b00) begin errors++; $display("FAIL mid_release: o_ready=%b o_valid=%b expected 11 00", o_ready, o_valid); end
        i_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (o_valid !== 2'b00) begin errors++; $display("FAIL mid_stale[%0d]: o_valid=%b o_flit=%h expected 00", k, o_valid, o_flit); end
        end
        i_valid = 2'b11;
        i_flit[0 +: FW]  = HT | 32'hF0;
        i_flit[FW +: FW] = HT | 32'hF1;
        tick();
        i_valid = '0;
        checks++; if (o_valid !== 2'b01 || o_flit !== (HT | 32'hF0)) begin errors++; $display("FAIL mid_rr_reset: o_valid=%b o_flit=%h expected 01 %h", o_valid, o_flit, HT | 32'hF0); end
        i_ready = '0;
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_latency();
        test_wormhole();
        test_round_robin();
        test_back_to_back_full();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
